// File: rtl/counter_seek_ctrl.sv
// rtl/counter_seek_ctrl.sv - drives an up/down counter to a requested target by stepping or loading
// Optional timeout on long seeks: define COUNTER_SEEK_TIMEOUT_EN.
module counter_seek_ctrl #(
    parameter int WIDTH     = 4,
    parameter int MAX_STEPS = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] target_i,
    input  logic             direct_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [WIDTH-1:0] steps_o,
    output logic             load_o,
    output logic             inc_o,
    output logic [WIDTH-1:0] data_o,
    input  logic [WIDTH-1:0] count_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOADW = 2'd1,
        S_SEEK  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

`ifdef COUNTER_SEEK_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [WIDTH-1:0] STEP_LIMIT = WIDTH'(MAX_STEPS);
    localparam logic [WIDTH-1:0] STEPS_SAT  = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] park_q, park_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] steps_q, steps_d;

    logic [WIDTH-1:0] dist_up;
    logic [WIDTH-1:0] dist_dn;
    logic             at_tgt;
    logic             timeout;

    // Modular distances; the shorter one wins and a tie goes up.
    assign dist_up = target_i - count_i;
    assign dist_dn = count_i - target_i;
    assign at_tgt  = (count_i == tgt_q);
    assign timeout = TIMEOUT_EN && (state_q == S_SEEK) && !at_tgt && (steps_q == STEP_LIMIT);

    assign busy_o  = (state_q != S_IDLE);
    assign steps_o = steps_q;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        park_d  = park_q;
        dir_d   = dir_q;
        steps_d = steps_q;
        load_o  = 1'b1;
        inc_o   = 1'b0;
        data_o  = park_q;
        done_o  = 1'b0;
        err_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The counter steps every cycle unless loaded, so idle keeps reloading the parked value.
                if (start_i) begin
                    tgt_d   = target_i;
                    steps_d = '0;
                    if (direct_i) begin
                        state_d = S_LOADW;
                    end else begin
                        dir_d   = (dist_up <= dist_dn);
                        state_d = S_SEEK;
                    end
                end
            end
            S_LOADW: begin
                data_o  = tgt_q;
                state_d = S_DONE;
            end
            S_SEEK: begin
                data_o = tgt_q;
                if (at_tgt) begin
                    state_d = S_DONE;
                end else if (timeout) begin
                    err_o   = 1'b1;
                    state_d = S_LOADW;
                end else begin
                    load_o  = 1'b0;
                    inc_o   = dir_q;
                    if (steps_q != STEPS_SAT) begin
                        steps_d = steps_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                data_o  = tgt_q;
                done_o  = 1'b1;
                park_d  = tgt_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            park_q  <= '0;
            dir_q   <= 1'b0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            park_q  <= park_d;
            dir_q   <= dir_d;
            steps_q <= steps_d;
        end
    end

endmodule

// File: tb/tb_counter_seek_ctrl.sv
// tb/tb_counter_seek_ctrl.sv - self-checking bench for counter_seek_ctrl with a behavioural counter
module tb_counter_seek_ctrl;

    localparam int W  = 4;
    localparam int MS = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         direct = 1'b0;
    logic [W-1:0] target = '0;
    logic         busy, done, err, load, inc;
    logic [W-1:0] steps, data;
    logic [W-1:0] cnt = '0;
    logic         stuck = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [W-1:0] model_cnt = '0;

    typedef struct {
        logic [W-1:0] cnt;
        logic [W-1:0] steps;
        int           lat;
    } exp_t;
    exp_t sb[$];

    counter_seek_ctrl #(.WIDTH(W), .MAX_STEPS(MS)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .target_i (target),
        .direct_i (direct),
        .busy_o   (busy),
        .done_o   (done),
        .err_o    (err),
        .steps_o  (steps),
        .load_o   (load),
        .inc_o    (inc),
        .data_o   (data),
        .count_i  (cnt)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (!stuck) cnt <= load ? data : (inc ? cnt + 1'b1 : cnt - 1'b1);
    end

    task automatic test_reset();
        #1;
        total_cnt++;
        if ({busy, done, err, load, inc, data, steps} !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0})
            $display("FAIL reset_outputs: busy=%0b done=%0b err=%0b load=%0b inc=%0b data=%0d steps=%0d, want 0 0 0 1 0 0 0",
                     busy, done, err, load, inc, data, steps);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (cnt !== 4'd0 || busy !== 1'b0) $display("FAIL reset_park: count=%0d busy=%0b, want 0 0", cnt, busy);
        else pass_cnt++;
        model_cnt = '0;
    endtask

    // hold_start keeps START high through the DONE cycle; it must be neither taken nor queued.
    task automatic test_move(input string name, input logic [W-1:0] t, input bit d, input bit hold_start);
        logic [W-1:0] up, dn;
        bit           dir_up, seen;
        int           n;
        exp_t         e, got;
        up = t - model_cnt;
        dn = model_cnt - t;
        dir_up = (up <= dn);
        e.cnt = t;
        e.steps = d ? 4'd0 : (dir_up ? up : dn);
        e.lat = d ? 2 : int'(e.steps) + 2;
        sb.push_back(e);

        @(posedge clk);
        #1 start = 1'b1; target = t; direct = d;
        @(posedge clk);
        #1 start = hold_start; target = t ^ 4'd5; direct = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL %s_busy: busy=%0b, want 1", name, busy);
        else pass_cnt++;
        if (d) begin
            total_cnt++;
            if (load !== 1'b1 || data !== t) $display("FAIL %s_load: load=%0b data=%0d, want 1 %0d", name, load, data, t);
            else pass_cnt++;
        end else if (e.steps != 0) begin
            total_cnt++;
            if (load !== 1'b0 || inc !== dir_up) $display("FAIL %s_dir: load=%0b inc=%0b, want 0 %0b", name, load, inc, dir_up);
            else pass_cnt++;
        end
        n = 1;
        seen = done;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            seen = done;
        end
        got.cnt = cnt;
        got.steps = steps;
        got.lat = n;
        if (hold_start) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        e = sb.pop_front();
        total_cnt++;
        if (!seen) $display("FAIL %s_done_timeout: no DONE in %0d cycles, want DONE", name, n);
        else pass_cnt++;
        total_cnt++;
        if (got.lat != e.lat) $display("FAIL %s_latency: got %0d, want %0d", name, got.lat, e.lat);
        else pass_cnt++;
        total_cnt++;
        if (got.cnt !== e.cnt) $display("FAIL %s_count: got %0d, want %0d", name, got.cnt, e.cnt);
        else pass_cnt++;
        total_cnt++;
        if (got.steps !== e.steps) $display("FAIL %s_steps: got %0d, want %0d", name, got.steps, e.steps);
        else pass_cnt++;
        if (!hold_start) @(negedge clk);
        else @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL %s_after: done=%0b busy=%0b, want 0 0", name, done, busy);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || cnt !== t || steps !== e.steps)
            $display("FAIL %s_park: busy=%0b count=%0d steps=%0d, want 0 %0d %0d", name, busy, cnt, steps, t, e.steps);
        else pass_cnt++;
        model_cnt = t;
    endtask

    task automatic test_reset_mid_seek();
        bit saw_done = 1'b0;
        @(posedge clk);
        #1 start = 1'b1; target = 4'd12; direct = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || load !== 1'b1 || data !== 4'd0 || done !== 1'b0)
            $display("FAIL rst_mid_outputs: busy=%0b load=%0b data=%0d done=%0b, want 0 1 0 0", busy, load, data, done);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        total_cnt++;
        if (saw_done || cnt !== 4'd0 || busy !== 1'b0)
            $display("FAIL rst_mid_after: done_seen=%0b count=%0d busy=%0b, want 0 0 0", saw_done, cnt, busy);
        else pass_cnt++;
        model_cnt = '0;
    endtask

    task automatic test_timeout();
        int err_at = -1;
        int done_at = -1;
        int err_n = 0;
        stuck = 1'b1;
        @(posedge clk);
        #1 start = 1'b1; target = 4'd7; direct = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (err) begin
                err_n++;
                if (err_at < 0) err_at = n;
            end
            if (done && done_at < 0) done_at = n;
        end
`ifdef COUNTER_SEEK_TIMEOUT_EN
        total_cnt++;
        if (err_at != MS + 1 || err_n != 1) $display("FAIL timeout_err: at %0d count %0d, want at %0d count 1", err_at, err_n, MS + 1);
        else pass_cnt++;
        total_cnt++;
        if (done_at != MS + 3 || steps !== 4'(MS)) $display("FAIL timeout_done: at %0d steps %0d, want at %0d steps %0d", done_at, steps, MS + 3, MS);
        else pass_cnt++;
`else
        total_cnt++;
        if (err_n != 0 || done_at >= 0) $display("FAIL noto_err: err pulses %0d done at %0d, want 0 and none", err_n, done_at);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL noto_busy: busy=%0b, want 1", busy);
        else pass_cnt++;
`endif
        stuck = 1'b0;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        model_cnt = '0;
    endtask

    initial begin
        test_reset();
        test_move("seek_up", 4'd3, 1'b0, 1'b0);
        test_move("seek_dn_wrap", 4'd14, 1'b0, 1'b0);
        test_move("seek_up_wrap", 4'd0, 1'b0, 1'b0);
        test_move("seek_tie", 4'd8, 1'b0, 1'b0);
        test_move("seek_zero", 4'd8, 1'b0, 1'b0);
        test_move("direct", 4'd9, 1'b1, 1'b1);
        test_move("back_to_back", 4'd6, 1'b0, 1'b1);
        test_reset_mid_seek();
        test_move("to_five", 4'd5, 1'b1, 1'b0);
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
